// File: rtl/pipelined_int_datapath.sv
// Three-stage Fetch / Decode-Read / Execute-Writeback integer datapath.
// ADD/AND in register and immediate forms, E->D forwarding, NZP condition codes.
module pipelined_int_datapath #(
  parameter int          REG_WIDTH = 16,
  parameter int          NUM_REGS  = 16,
  parameter int          PC_WIDTH  = 16,
  parameter int          IMEM_AW   = 6,
  parameter logic [4:0]  OP_ADD    = 5'd1,
  parameter logic [4:0]  OP_AND    = 5'd5,
  localparam int         RIW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock,
  output logic [IMEM_AW-1:0]   imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic                 wb_valid,
  output logic [RIW-1:0]       wb_reg,
  output logic [REG_WIDTH-1:0] wb_data,
  output logic [2:0]           cc,
  input  logic [RIW-1:0]       dbg_idx,
  output logic [REG_WIDTH-1:0] dbg_data
);

  logic [PC_WIDTH-1:0]  pc_r;
  logic [31:0]          ir_d_r;
  logic                 valid_d_r;
  logic                 valid_e_r;
  logic [4:0]           op_e_r;
  logic [RIW-1:0]       dst_e_r;
  logic [REG_WIDTH-1:0] src1_e_r;
  logic [REG_WIDTH-1:0] op2_e_r;
  logic [REG_WIDTH-1:0] regs_r [NUM_REGS];
  logic [2:0]           cc_r;

  logic [RIW-1:0]       src1_idx_s;
  logic [RIW-1:0]       src2_idx_s;
  logic [REG_WIDTH-1:0] imm_s;
  logic [REG_WIDTH-1:0] src1_s;
  logic [REG_WIDTH-1:0] src2_s;
  logic [REG_WIDTH-1:0] op2_s;
  logic [REG_WIDTH-1:0] result_s;
  logic                 is_alu_s;
  logic                 commit_s;
  logic                 unused_s;

  function automatic logic [2:0] nzp_of(input logic [REG_WIDTH-1:0] v);
    logic zero;
    zero = (v == {REG_WIDTH{1'b0}});
    return {v[REG_WIDTH-1], zero, !v[REG_WIDTH-1] && !zero};
  endfunction

  assign src1_idx_s = ir_d_r[16 +: RIW];
  assign src2_idx_s = ir_d_r[8 +: RIW];
  assign imm_s      = REG_WIDTH'(ir_d_r[15:0]);
  // A write is only real on an advancing, non-reset edge.
  assign commit_s   = is_alu_s && lock && rst_n;
  assign unused_s   = ^{pc_r, ir_d_r, valid_d_r};

  // Execute: ALU result and whether this instruction writes back.
  always_comb begin
    result_s = {REG_WIDTH{1'b0}};
    is_alu_s = 1'b0;
    case (op_e_r)
      OP_ADD: begin
        result_s = src1_e_r + op2_e_r;
        is_alu_s = valid_e_r;
      end
      OP_AND: begin
        result_s = src1_e_r & op2_e_r;
        is_alu_s = valid_e_r;
      end
      default: begin
        result_s = {REG_WIDTH{1'b0}};
        is_alu_s = 1'b0;
      end
    endcase
  end

  // Decode: register read with bypass from the instruction committing now.
  always_comb begin
    src1_s = {REG_WIDTH{1'b0}};
    src2_s = {REG_WIDTH{1'b0}};
    op2_s  = {REG_WIDTH{1'b0}};
    if (commit_s && (dst_e_r == src1_idx_s)) begin
      src1_s = result_s;
    end else begin
      src1_s = regs_r[src1_idx_s];
    end
    if (commit_s && (dst_e_r == src2_idx_s)) begin
      src2_s = result_s;
    end else begin
      src2_s = regs_r[src2_idx_s];
    end
    if (ir_d_r[24]) begin
      op2_s = imm_s;
    end else begin
      op2_s = src2_s;
    end
  end

  // Pipeline registers, register file and condition codes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r      <= {PC_WIDTH{1'b0}};
      ir_d_r    <= 32'h0000_0000;
      valid_d_r <= 1'b0;
      valid_e_r <= 1'b0;
      op_e_r    <= 5'd0;
      dst_e_r   <= {RIW{1'b0}};
      src1_e_r  <= {REG_WIDTH{1'b0}};
      op2_e_r   <= {REG_WIDTH{1'b0}};
      cc_r      <= 3'b000;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {REG_WIDTH{1'b0}};
      end
    end else if (lock) begin
      pc_r      <= pc_r + PC_WIDTH'(3'd4);
      ir_d_r    <= imem_rdata;
      valid_d_r <= 1'b1;
      valid_e_r <= valid_d_r;
      op_e_r    <= ir_d_r[31:27];
      dst_e_r   <= ir_d_r[20 +: RIW];
      src1_e_r  <= src1_s;
      op2_e_r   <= op2_s;
      if (is_alu_s) begin
        regs_r[dst_e_r] <= result_s;
        cc_r            <= nzp_of(result_s);
      end
    end
  end

  assign imem_addr = pc_r[IMEM_AW+1:2];
  assign wb_valid  = commit_s;
  assign wb_reg    = dst_e_r;
  assign wb_data   = result_s;
  assign cc        = cc_r;
  assign dbg_data  = regs_r[dbg_idx];

endmodule

// File: tb/tb_pipelined_int_datapath.sv
// Scoreboard bench: an instruction-level model queues expected commits; a negedge
// monitor pops them against wb_* and tracks the committed register/cc state.
module tb_pipelined_int_datapath;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_AND = 5'd5;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
    logic [2:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock = 1'b1;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic [2:0]  cc;
  logic [3:0]  dbg_idx = 4'd0;
  logic [15:0] dbg_data;

  logic [31:0] rom [64];
  logic [31:0] prog [$];
  exp_t        sb [$];
  int          commit_edges [$];
  logic [15:0] m_regs [16];
  logic [2:0]  m_cc;
  logic [15:0] cm_regs [16];
  logic [2:0]  cm_cc;
  logic        mon_en = 1'b0;
  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  pipelined_int_datapath #(.OP_ADD(OP_ADD), .OP_AND(OP_AND)) dut (
    .clk(clk), .rst_n(rst_n), .lock(lock),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .cc(cc),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  initial forever #50 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else if (lock) edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: cc must match the committed model, each wb_valid pops one item.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      check("cc_track", 32'(cc), 32'(cm_cc));
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("spurious_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("wb_reg", 32'(wb_reg), 32'(e.r));
          check("wb_data", 32'(wb_data), 32'(e.d));
          cm_regs[e.r] = e.d;
          cm_cc = e.c;
          commit_edges.push_back(edge_cnt);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(logic [4:0] op, logic [3:0] d, logic [3:0] s1, logic [15:0] imm);
    return {op, 2'b00, 1'b1, d, s1, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] op, logic [3:0] d, logic [3:0] s1, logic [3:0] s2);
    return {op, 2'b00, 1'b0, d, s1, 4'h0, s2, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: execute one word, queue the commit it implies.
  task automatic exec(input logic [31:0] w);
    logic [15:0] op2, res;
    exp_t e;
    op2 = w[24] ? w[15:0] : m_regs[w[11:8]];
    if (w[31:27] == OP_ADD) res = m_regs[w[19:16]] + op2;
    else if (w[31:27] == OP_AND) res = m_regs[w[19:16]] & op2;
    else return;
    m_regs[w[23:20]] = res;
    m_cc = {res[15], res == 16'h0, !res[15] && res != 16'h0};
    e.r = w[23:20];
    e.d = res;
    e.c = m_cc;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    rst_n = 1'b0;
    lock = 1'b1;
    repeat (n) tick();
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_cc", 32'(cc), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      check($sformatf("rst_reg%0d", i), 32'(dbg_data), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      cm_regs[i] = 16'h0;
    end
    m_cc = 3'b000;
    cm_cc = 3'b000;
    sb.delete();
    commit_edges.delete();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic start_prog();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    foreach (prog[i]) rom[i] = prog[i];
    do_reset(2);
    foreach (prog[i]) exec(prog[i]);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      check($sformatf("final_reg%0d", i), 32'(dbg_data), 32'(m_regs[i]));
    end
    check("final_cc", 32'(cc), 32'(m_cc));
  endtask

  task automatic peek(input string tag, input int idx, input logic [15:0] exp);
    dbg_idx = 4'(idx);
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    do_reset(2);

    // Dependent ADD right behind its producers, commits back to back.
    prog = '{enc_i(OP_ADD, 4'd1, 4'd0, 16'd5), enc_i(OP_ADD, 4'd2, 4'd0, 16'd3),
             enc_r(OP_ADD, 4'd3, 4'd1, 4'd2)};
    start_prog();
    run(8);
    peek("t2_r3", 3, 16'd8);
    check("t2_cc", 32'(cc), 32'(3'b001));
    check("t2_commit_count", 32'(commit_edges.size()), 32'd3);
    if (commit_edges.size() == 3) begin
      for (int j = 0; j < 3; j++) check($sformatf("t2_commit_edge%0d", j), 32'(commit_edges[j]), 32'(j + 2));
    end

    // Wrap to zero, then negative result.
    prog = '{enc_i(OP_ADD, 4'd1, 4'd0, 16'hFFFF), enc_i(OP_ADD, 4'd1, 4'd1, 16'd1),
             enc_i(OP_ADD, 4'd2, 4'd0, 16'h8000)};
    start_prog();
    run(8);
    peek("t3_r1", 1, 16'h0000);
    peek("t3_r2", 2, 16'h8000);
    check("t3_cc", 32'(cc), 32'(3'b100));

    // AND register and immediate forms.
    prog = '{enc_i(OP_ADD, 4'd1, 4'd0, 16'h00F0), enc_r(OP_AND, 4'd4, 4'd1, 4'd1),
             enc_i(OP_AND, 4'd5, 4'd1, 16'h0F0F)};
    start_prog();
    run(8);
    peek("t4_r4", 4, 16'h00F0);
    peek("t4_r5", 5, 16'h0000);
    check("t4_cc", 32'(cc), 32'(3'b010));

    // Freeze the pipeline for four cycles mid-program.
    prog = '{enc_i(OP_ADD, 4'd1, 4'd0, 16'd1), enc_r(OP_ADD, 4'd1, 4'd1, 4'd1),
             enc_r(OP_ADD, 4'd1, 4'd1, 4'd1), enc_i(OP_ADD, 4'd6, 4'd1, 16'h0010),
             enc_r(OP_AND, 4'd7, 4'd6, 4'd1), enc_r(OP_ADD, 4'd8, 4'd7, 4'd6)};
    start_prog();
    repeat (3) tick();
    lock = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lock_imem_addr", 32'(imem_addr), 32'd3);
      check("lock_wb_valid", 32'(wb_valid), 32'd0);
      check("lock_cc", 32'(cc), 32'(cm_cc));
      for (int i = 0; i < 16; i++) begin
        dbg_idx = 4'(i);
        #1;
        check($sformatf("lock_reg%0d", i), 32'(dbg_data), 32'(cm_regs[i]));
      end
    end
    lock = 1'b1;
    run(12);
    peek("t5_r8", 8, 16'h0018);

    // Unknown opcodes between writers leave registers and cc alone.
    prog = '{enc_i(OP_ADD, 4'd1, 4'd0, 16'd7), enc_i(5'h1F, 4'd1, 4'd0, 16'h1234),
             enc_r(OP_ADD, 4'd2, 4'd1, 4'd1), enc_r(5'h00, 4'd1, 4'd2, 4'd2),
             enc_i(OP_AND, 4'd9, 4'd2, 16'h000F)};
    start_prog();
    run(10);
    peek("t6_r1", 1, 16'd7);
    peek("t6_r9", 9, 16'd14);

    // Reset after a single fetch flushes it and restarts at address 0.
    prog = '{enc_i(OP_ADD, 4'd3, 4'd0, 16'd9)};
    start_prog();
    tick();
    check("t6_one_fetch", 32'(imem_addr), 32'd1);
    do_reset(1);
    foreach (prog[i]) exec(prog[i]);
    run(6);
    peek("t6_r3", 3, 16'd9);
    check("t6_restart_count", 32'(commit_edges.size()), 32'd1);
    if (commit_edges.size() == 1) check("t6_restart_edge", 32'(commit_edges[0]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
